// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and FSM state encoding for seq_alu.
//   ST_*  : controller states (IDLE/BUSY/DONE)
//   OP_*  : 5-bit alu_code values
//   is_signed_op() : codes that report signed overflow from the adder
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SUBU = 5'b00011;
  localparam logic [4:0] OP_INC  = 5'b00100;
  localparam logic [4:0] OP_DEC  = 5'b00101;
  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b10001;
  localparam logic [4:0] OP_SLA  = 5'b10010;
  localparam logic [4:0] OP_SRA  = 5'b10011;
  localparam logic [4:0] OP_SLE  = 5'b11000;
  localparam logic [4:0] OP_SLT  = 5'b11001;
  localparam logic [4:0] OP_SGE  = 5'b11010;
  localparam logic [4:0] OP_SGT  = 5'b11011;
  localparam logic [4:0] OP_SEQ  = 5'b11100;
  localparam logic [4:0] OP_SNE  = 5'b11101;

  function automatic logic is_signed_op(input logic [4:0] code);
    return code inside {OP_ADD, OP_SUB, OP_INC, OP_DEC};
  endfunction

endpackage

// File: rtl/seq_mul.sv
// seq_mul: unsigned shift-add multiplier, one multiplier bit per clock.
//   clk, rst     : clock, asynchronous active-high reset
//   i_start      : load i_a (multiplicand) and i_b (multiplier), begin
//   o_done       : high once WIDTH iterations are complete (until next cycle)
//   o_product    : full 2*WIDTH-bit product, valid while o_done is high
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  // Low half starts as the multiplier and is shifted out as the product fills in.
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic               w_done;

  assign w_addend = r_prod[0] ? r_mcand : {WIDTH{1'b0}};
  assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_done   = r_busy && (r_cnt == CW'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_prod  <= {{WIDTH{1'b0}}, i_b};
      r_mcand <= i_a;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (w_done) begin
      r_busy  <= 1'b0;
    end else if (r_busy) begin
      r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_done    = w_done;
  assign o_product = r_prod;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with single-cycle arithmetic/logic/shift/set ops and
// an iterative multiply.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : request handshake (ready only in IDLE)
//   A, B, alu_code      : operands and operation, captured at accept
//   out_valid, out_ready: result handshake (valid only in DONE)
//   C                   : result
//   overflow, carry     : status flags; zero = (C == 0)
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       alu_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             overflow,
  output logic             carry,
  output logic             zero
);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_c;
  logic               r_ovf;
  logic               r_carry;
  logic               r_zero;

  logic               w_accept;
  logic               w_start_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;

  logic [WIDTH-1:0]   w_b_sel;
  logic               w_inv;
  logic               w_cin;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic               w_add_ovf;
  logic               w_lt;
  logic               w_eq;
  logic [SHW-1:0]     w_shamt;
  logic               w_set;
  logic [WIDTH-1:0]   w_c;
  logic               w_ovf;
  logic               w_carry;

  assign w_accept    = in_valid && in_ready;
  assign w_start_mul = w_accept && (alu_code == OP_MUL);

  // Single shared adder: subtract/compare invert B with carry-in 1, inc adds
  // 0 with carry-in 1, dec adds all-ones with carry-in 0.
  always_comb begin
    w_b_sel = B;
    w_inv   = 1'b0;
    w_cin   = 1'b0;
    case (alu_code)
      OP_SUB, OP_SUBU, OP_SLE, OP_SLT, OP_SGE, OP_SGT, OP_SEQ, OP_SNE: begin
        w_inv = 1'b1;
        w_cin = 1'b1;
      end
      OP_INC: begin
        w_b_sel = '0;
        w_cin   = 1'b1;
      end
      OP_DEC: begin
        w_b_sel = '0;
        w_inv   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_b       = w_inv ? ~w_b_sel : w_b_sel;
  assign w_sum     = {1'b0, A} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_add_ovf = (A[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  // Sign of A-B corrected by its overflow gives a true signed less-than.
  assign w_lt      = w_sum[WIDTH-1] ^ w_add_ovf;
  assign w_eq      = (w_sum[WIDTH-1:0] == '0);
  assign w_shamt   = B[SHW-1:0];

  // Unlisted codes (and MUL, resolved later) fall through to C = 0, flags 0.
  always_comb begin
    w_c     = '0;
    w_ovf   = 1'b0;
    w_carry = 1'b0;
    w_set   = 1'b0;
    case (alu_code)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_INC, OP_DEC: begin
        w_c     = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = is_signed_op(alu_code) && w_add_ovf;
      end
      OP_AND:         w_c = A & B;
      OP_OR:          w_c = A | B;
      OP_XOR:         w_c = A ^ B;
      OP_NOT:         w_c = ~A;
      OP_SLL, OP_SLA: w_c = A << w_shamt;
      OP_SRL:         w_c = A >> w_shamt;
      OP_SRA:         w_c = $signed(A) >>> w_shamt;
      OP_SLE, OP_SLT, OP_SGE, OP_SGT, OP_SEQ, OP_SNE: begin
        case (alu_code)
          OP_SLE:  w_set = w_lt | w_eq;
          OP_SLT:  w_set = w_lt;
          OP_SGE:  w_set = ~w_lt;
          OP_SGT:  w_set = ~w_lt & ~w_eq;
          OP_SEQ:  w_set = w_eq;
          default: w_set = ~w_eq;
        endcase
        w_c = {{(WIDTH-1){1'b0}}, w_set};
      end
      default: ;
    endcase
  end

  seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start_mul),
    .i_a      (A),
    .i_b      (B),
    .o_done   (w_mul_done),
    .o_product(w_product)
  );

  // Result registers only load on IDLE accept or multiplier completion, so they
  // hold through DONE back-pressure and ignore requests made outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (alu_code == OP_MUL) begin
              r_state <= ST_BUSY;
            end else begin
              r_state <= ST_DONE;
              r_c     <= w_c;
              r_ovf   <= w_ovf;
              r_carry <= w_carry;
              r_zero  <= (w_c == '0);
            end
          end
        end
        ST_BUSY: begin
          if (w_mul_done) begin
            r_state <= ST_DONE;
            r_c     <= w_product[WIDTH-1:0];
            r_ovf   <= |w_product[2*WIDTH-1:WIDTH];
            r_carry <= 1'b0;
            r_zero  <= (w_product[WIDTH-1:0] == '0);
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign C         = r_c;
  assign overflow  = r_ovf;
  assign carry     = r_carry;
  assign zero      = r_zero;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; any value >= 4 SHALL be supported.
REQ-002 Parameter: SHW, default $clog2(WIDTH), number of low B bits used as the shift amount.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous and active-high.
REQ-005 Port: in_valid  input  1  operation request.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: A  input  WIDTH  operand A.
REQ-008 Port: B  input  WIDTH  operand B, also the shift amount (B[SHW-1:0]).
REQ-009 Port: alu_code  input  5  operation select.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: C  output  WIDTH  result.
REQ-013 Port: overflow  output  1  signed overflow, or nonzero upper product half for MUL.
REQ-014 Port: carry  output  1  carry out of add/inc; NOT borrow for subtract/dec.
REQ-015 Port: zero  output  1  C == 0.

Function
REQ-016 FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-017 Transitions: IDLE -> DONE on accept of a single-cycle op; IDLE -> BUSY on accept of MUL; BUSY -> DONE after WIDTH iterations; DONE -> IDLE on out_valid && out_ready.
REQ-018 in_ready SHALL equal (state == IDLE); accept = in_valid && in_ready; A, B and alu_code SHALL be registered at accept and ignored otherwise.
REQ-019 out_valid SHALL equal (state == DONE); C and all flags SHALL hold stable while out_valid && !out_ready.
REQ-020 Latency: single-cycle ops SHALL present out_valid in the cycle after accept; MUL SHALL present out_valid WIDTH+1 cycles after accept.
REQ-021 Arithmetic codes: 00000 signed add; 00001 unsigned add; 00010 signed sub; 00011 unsigned sub; 00100 A+1; 00101 A-1; 00110 MUL (unsigned shift-add, one bit per cycle, C = low WIDTH bits).
REQ-022 Overflow SHALL be computed only for the signed codes 00000/00010/00100/00101, as operand MSBs equal-after-B-inversion and result MSB different; for all other codes overflow SHALL be 0, except MUL (REQ-013).
REQ-023 Logic codes: 01000 AND; 01001 OR; 01010 XOR; 01100 NOT A.
REQ-024 Shift codes: 10000 logical left; 10001 logical right; 10010 arithmetic left (equal to logical left); 10011 arithmetic right (sign fill); the amount SHALL be B[SHW-1:0]; shifts SHALL set overflow = 0 and carry = 0.
REQ-025 Set codes (signed compare, C = 1 or 0): 11000 A<=B; 11001 A<B; 11010 A>=B; 11011 A>B; 11100 A==B; 11101 A!=B.
REQ-026 Less-than SHALL be computed as sign(A-B) XOR overflow(A-B), so that it is correct at the extremes.
REQ-027 Any unlisted code SHALL produce C = 0 and all flags = 0, with single-cycle latency.
REQ-028 zero SHALL reflect the registered C for every code.
REQ-029 in_valid while state != IDLE SHALL be ignored: no queueing and no corruption of an operation in flight.

Reset
REQ-030 rst SHALL force state = IDLE, out_valid = 0, C = 0, overflow = 0, carry = 0, zero = 0, and clear the multiplier registers.
REQ-031 rst asserted mid-MUL or mid-DONE SHALL abort the operation; in_ready SHALL be 1 in the first cycle after deassertion.

Structure
REQ-032 The opcode localparams and the FSM state encoding SHALL live in a shared package, alu_pkg.
REQ-033 The iterative multiplier SHALL be the one sub-module, seq_mul (start/done handshake, WIDTH-parameterised).
REQ-034 The add/sub/compare datapath SHALL use a single WIDTH+1-bit adder with B inversion and carry-in.

Verification
REQ-035 WIDTH=16, signed add A=16'h7FFF, B=16'h0001 -> C=16'h8000, overflow=1, carry=0, zero=0, one cycle after accept.
REQ-036 Unsigned sub A=16'h0000, B=16'h0001 -> C=16'hFFFF, carry=0, overflow=0; set-less A=16'h8000, B=16'h7FFF (code 11001) -> C=1.
REQ-037 MUL A=16'h0100, B=16'h0100 -> C=16'h0000, overflow=1, zero=1, out_valid 17 cycles after accept; in_ready=0 throughout BUSY.
REQ-038 Arithmetic right shift A=16'h8000, B=16'h0013 (amount 3) -> C=16'hF000; logical right -> C=16'h1000.
REQ-039 Hold out_ready=0 for 5 cycles after a result -> C and flags stable and in_valid ignored; rst pulsed at BUSY cycle 7 -> out_valid=0 and in_ready=1 after release.
